// File: rtl/cronometro_7seg.sv
// rtl/cronometro_7seg.sv - HH:MM:SS.CC stopwatch with BCD ripple counter and active-low 7-segment outputs
module cronometro_7seg #(
  parameter int DIV = 500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        clear,
  output logic [55:0] chx,
  output logic        running,
  output logic        estouro
);

  localparam int              PW        = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(DIV - 1);
  localparam logic [31:0]     BCD_MAX   = 32'h9959_5999;

  typedef enum logic [1:0] {ZERADO, CONTANDO, PARADO} state_t;

  state_t        state, state_next;
  logic          ss_samp, ss_prev, ss_arm;
  logic          cl_samp, cl_prev, cl_arm;
  logic          ss_cmd, cl_cmd;
  logic [PW-1:0] presc;
  logic [31:0]   bcd, bcd_next;
  logic          count_en, tick, carry;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // arm flags only set after a low sample, so a button held through reset is ignored
  always_ff @(posedge clock) begin
    if (reset) begin
      ss_samp <= 1'b0;
      ss_prev <= 1'b0;
      ss_arm  <= 1'b0;
      cl_samp <= 1'b0;
      cl_prev <= 1'b0;
      cl_arm  <= 1'b0;
    end else begin
      ss_samp <= start_stop;
      ss_prev <= ss_samp;
      ss_arm  <= ss_arm | ~start_stop;
      cl_samp <= clear;
      cl_prev <= cl_samp;
      cl_arm  <= cl_arm | ~clear;
    end
  end

  assign ss_cmd = ss_samp & ~ss_prev & ss_arm;
  assign cl_cmd = cl_samp & ~cl_prev & cl_arm;

  always_ff @(posedge clock) begin
    if (reset) state <= ZERADO;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    count_en   = 1'b0;
    if (cl_cmd) begin
      state_next = ZERADO;
    end else if (ss_cmd) begin
      case (state)
        ZERADO:   state_next = CONTANDO;
        CONTANDO: state_next = PARADO;
        PARADO:   state_next = CONTANDO;
        default:  state_next = ZERADO;
      endcase
    end else if (state == CONTANDO) begin
      count_en = 1'b1;
    end
  end

  assign tick = count_en && (presc == PRESC_MAX);

  // limits per digit come from BCD_MAX, so the carry ripples through all eight digits in one cycle
  always_comb begin
    bcd_next = bcd;
    carry    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (carry) begin
        if (bcd[4*i +: 4] == BCD_MAX[4*i +: 4]) begin
          bcd_next[4*i +: 4] = 4'd0;
        end else begin
          bcd_next[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || cl_cmd)                presc <= '0;
    else if (state == ZERADO && ss_cmd) presc <= '0;
    else if (tick)                      presc <= '0;
    else if (count_en)                  presc <= presc + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bcd     <= '0;
      chx     <= {8{7'h40}};
      running <= 1'b0;
      estouro <= 1'b0;
    end else begin
      if (cl_cmd)    bcd <= '0;
      else if (tick) bcd <= bcd_next;
      for (int n = 0; n < 8; n++) chx[7*n +: 7] <= seg7(bcd[4*n +: 4]);
      running <= (state_next == CONTANDO);
      estouro <= tick && (bcd == BCD_MAX);
    end
  end

endmodule

// File: tb/tb_cronometro_7seg.sv
// tb/tb_cronometro_7seg.sv - table, directed and randomized checks of cronometro_7seg against an integer-count model
module tb_cronometro_7seg;

  localparam int MAXC = 100 * 360000 - 1;
  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    bit          s_samp, s_prev, s_arm;
    bit          c_samp, c_prev, c_arm;
    int          mode;   // 0 idle at zero, 1 counting, 2 paused
    int          presc;
    int          count;  // elapsed hundredths
    logic [55:0] chx;
    bit          running;
    bit          estouro;
  } mdl_t;

  typedef struct {
    bit rst;
    bit ss;
    bit cl;
    int n;
    bit exp_run;
    int exp_cnt;
  } vec_t;

  logic        clock;
  logic        rst_a, ss_a, cl_a, run_a, ov_a;
  logic [55:0] chx_a;
  logic        rst_b, ss_b, cl_b, run_b, ov_b;
  logic [55:0] chx_b;

  int   n_checks;
  int   n_fail;
  mdl_t ma, mb;
  vec_t tab [18];

  cronometro_7seg #(.DIV(4)) dut_a (
    .clock(clock), .reset(rst_a), .start_stop(ss_a), .clear(cl_a),
    .chx(chx_a), .running(run_a), .estouro(ov_a)
  );

  cronometro_7seg #(.DIV(2)) dut_b (
    .clock(clock), .reset(rst_b), .start_stop(ss_b), .clear(cl_b),
    .chx(chx_b), .running(run_b), .estouro(ov_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [55:0] show(input int cnt);
    int cc, s, mi, h;
    int d [8];
    logic [55:0] r;
    cc = cnt % 100;
    s  = (cnt / 100) % 60;
    mi = (cnt / 6000) % 60;
    h  = cnt / 360000;
    d[0] = cc % 10; d[1] = cc / 10;
    d[2] = s % 10;  d[3] = s / 10;
    d[4] = mi % 10; d[5] = mi / 10;
    d[6] = h % 10;  d[7] = h / 10;
    for (int n = 0; n < 8; n++) r[7*n +: 7] = SEG_TAB[d[n]];
    return r;
  endfunction

  function automatic mdl_t mreset();
    mdl_t m;
    m.s_samp = 0; m.s_prev = 0; m.s_arm = 0;
    m.c_samp = 0; m.c_prev = 0; m.c_arm = 0;
    m.mode = 0; m.presc = 0; m.count = 0;
    m.chx = show(0);
    m.running = 0; m.estouro = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit rst, input bit ss, input bit cl, input int div);
    mdl_t n;
    bit cmd_s, cmd_c;
    if (rst) return mreset();
    n = m;
    cmd_s = m.s_samp && !m.s_prev && m.s_arm;
    cmd_c = m.c_samp && !m.c_prev && m.c_arm;
    n.s_samp = ss; n.s_prev = m.s_samp; n.s_arm = m.s_arm || !ss;
    n.c_samp = cl; n.c_prev = m.c_samp; n.c_arm = m.c_arm || !cl;
    n.chx = show(m.count);
    n.estouro = 0;
    if (cmd_c) begin
      n.mode = 0; n.count = 0; n.presc = 0;
    end else if (cmd_s) begin
      if (m.mode == 0) begin
        n.mode = 1; n.presc = 0;
      end else if (m.mode == 1) n.mode = 2;
      else n.mode = 1;
    end else if (m.mode == 1) begin
      n.presc = m.presc + 1;
      if (n.presc == div) begin
        n.presc = 0;
        n.count = m.count + 1;
        if (n.count > MAXC) begin
          n.count = 0;
          n.estouro = 1;
        end
      end
    end
    n.running = (n.mode == 1);
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc_a(input bit r, input bit s, input bit c);
    rst_a = r; ss_a = s; cl_a = c;
    @(posedge clock);
    ma = mstep(ma, r, s, c, 4);
    #1;
    chk("a_chx", {8'h0, chx_a}, {8'h0, ma.chx});
    chk("a_running", {63'h0, run_a}, {63'h0, ma.running});
    chk("a_estouro", {63'h0, ov_a}, {63'h0, ma.estouro});
  endtask

  task automatic cyc_b(input bit r, input bit s, input bit c);
    rst_b = r; ss_b = s; cl_b = c;
    @(posedge clock);
    mb = mstep(mb, r, s, c, 2);
    #1;
    chk("b_chx", {8'h0, chx_b}, {8'h0, mb.chx});
    chk("b_running", {63'h0, run_b}, {63'h0, mb.running});
    chk("b_estouro", {63'h0, ov_b}, {63'h0, mb.estouro});
  endtask

  function automatic vec_t mk(input bit r, input bit s, input bit c, input int n, input bit er, input int ec);
    vec_t v;
    v.rst = r; v.ss = s; v.cl = c; v.n = n; v.exp_run = er; v.exp_cnt = ec;
    return v;
  endfunction

  initial begin
    logic [55:0] carry_exp;
    bit          rs, rc, rr, prev_ov;
    int          guard, ov_cnt;

    n_checks = 0;
    n_fail   = 0;
    ma = mreset();
    mb = mreset();
    rst_a = 1'b1; ss_a = 1'b1; cl_a = 1'b0;
    rst_b = 1'b1; ss_b = 1'b0; cl_b = 1'b0;

    // DIV=4: reset with button held, start, 10 ticks, pause/resume, clear+start, reset mid-count
    tab[0]  = mk(1'b1, 1'b1, 1'b0,  2, 1'b0,  0);
    tab[1]  = mk(1'b0, 1'b1, 1'b0,  5, 1'b0,  0);
    tab[2]  = mk(1'b0, 1'b0, 1'b0,  1, 1'b0,  0);
    tab[3]  = mk(1'b0, 1'b1, 1'b0,  1, 1'b0,  0);
    tab[4]  = mk(1'b0, 1'b1, 1'b0,  1, 1'b1,  0);
    tab[5]  = mk(1'b0, 1'b0, 1'b0, 41, 1'b1, 10);
    tab[6]  = mk(1'b0, 1'b1, 1'b0,  2, 1'b0, 10);
    tab[7]  = mk(1'b0, 1'b0, 1'b0, 20, 1'b0, 10);
    tab[8]  = mk(1'b0, 1'b1, 1'b0,  2, 1'b1, 10);
    tab[9]  = mk(1'b0, 1'b0, 1'b0,  2, 1'b1, 10);
    tab[10] = mk(1'b0, 1'b0, 1'b0,  1, 1'b1, 11);
    tab[11] = mk(1'b0, 1'b1, 1'b1,  2, 1'b0, 11);
    tab[12] = mk(1'b0, 1'b0, 1'b0,  1, 1'b0,  0);
    tab[13] = mk(1'b0, 1'b0, 1'b0,  5, 1'b0,  0);
    tab[14] = mk(1'b0, 1'b1, 1'b0,  2, 1'b1,  0);
    tab[15] = mk(1'b0, 1'b0, 1'b0, 10, 1'b1,  2);
    tab[16] = mk(1'b1, 1'b1, 1'b0,  1, 1'b0,  0);
    tab[17] = mk(1'b0, 1'b1, 1'b0,  3, 1'b0,  0);

    for (int v = 0; v < 18; v++) begin
      for (int k = 0; k < tab[v].n; k++) cyc_a(tab[v].rst, tab[v].ss, tab[v].cl);
      chk($sformatf("tab%0d_chx", v), {8'h0, chx_a}, {8'h0, show(tab[v].exp_cnt)});
      chk($sformatf("tab%0d_running", v), {63'h0, run_a}, {63'h0, tab[v].exp_run});
    end

    rs = 1'b1; rc = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0)   rs = ~rs;
      if ($urandom_range(39) == 0)  rc = ~rc;
      rr = ($urandom_range(499) == 0);
      cyc_a(rr, rs, rc);
    end

    // DIV=2: count up to 00:01:00.00
    cyc_b(1'b1, 1'b0, 1'b0);
    cyc_b(1'b1, 1'b0, 1'b0);
    cyc_b(1'b0, 1'b0, 1'b0);
    cyc_b(1'b0, 1'b1, 1'b0);
    cyc_b(1'b0, 1'b1, 1'b0);
    guard = 0;
    while (mb.count != 6000 && guard < 20000) begin
      cyc_b(1'b0, 1'b0, 1'b0);
      guard++;
    end
    chk("b_carry_reached", {63'h0, (guard < 20000)}, 64'h1);
    cyc_b(1'b0, 1'b0, 1'b0);
    carry_exp = {7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40};
    chk("b_carry_display", {8'h0, chx_b}, {8'h0, carry_exp});

    // pause, preload 99:59:59.99, resume and watch the wrap
    cyc_b(1'b0, 1'b1, 1'b0);
    cyc_b(1'b0, 1'b1, 1'b0);
    chk("b_paused", {63'h0, run_b}, 64'h0);
    force dut_b.bcd = 32'h9959_5999;
    mb.count = MAXC;
    cyc_b(1'b0, 1'b0, 1'b0);
    cyc_b(1'b0, 1'b0, 1'b0);
    release dut_b.bcd;
    cyc_b(1'b0, 1'b0, 1'b0);
    cyc_b(1'b0, 1'b0, 1'b0);
    cyc_b(1'b0, 1'b1, 1'b0);
    cyc_b(1'b0, 1'b1, 1'b0);
    ov_cnt  = 0;
    prev_ov = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc_b(1'b0, 1'b0, 1'b0);
      if (prev_ov) chk("b_chx_after_wrap", {8'h0, chx_b}, {8'h0, {8{7'h40}}});
      prev_ov = ov_b;
      if (ov_b) ov_cnt++;
    end
    chk("b_estouro_pulses", 64'(ov_cnt), 64'd1);
    chk("b_running_after_wrap", {63'h0, run_b}, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cronometro_7seg.md
Name: cronometro_7seg

Overview:
- Stopwatch core that counts elapsed time as HH:MM:SS.CC (hundredths of a second, up to 99:59:59.99).
- Each of the eight BCD digits is encoded to active-low seven-segment codes.
- It is the stage directly upstream of the display selector and drives that selector's stopwatch-side segment inputs (CHXnk).
- Start/stop and clear commands come from already-debounced push-button levels.

Parameters:
- DIV, 500000: clock cycles per 1/100 s tick (50 MHz board clock); must be ≥ 2.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start_stop  in  1  debounced level, active-high; a rising edge is one start/stop command.
- clear  in  1  debounced level, active-high; a rising edge is one clear command.
- chx  out  56  segment bus: chx[7n+k] drives display n, segment k (maps to CHXnk); n=0 is hundredths units, n=7 is hours tens; k=0..6 = segments a..g; active-low.
- running  out  1  high while in state CONTANDO.
- estouro  out  1  one-cycle pulse when the count wraps 99:59:59.99 -> 00:00:00.00.

Behaviour:
- All logic is synchronous to clock; reset is sampled only on a rising edge.
- Reset values:
  - All BCD digits = 0, so chx = {8{7'h40}} (every display shows "0").
  - running = 0, estouro = 0, state = ZERADO.
  - Prescaler = 0; edge-detect history registers = 0.
- Edge detection: a command is a registered-input rising edge (previous sample 0, current sample 1).
  - A level held high produces exactly one command.
  - A button that is high at reset release produces no command until it goes low and high again.
- States:
  - ZERADO: count is zero and idle.
  - CONTANDO: counting.
  - PARADO: frozen at a nonzero value.
- Transitions:
  - ZERADO + start_stop -> CONTANDO, with prescaler cleared.
  - CONTANDO + start_stop -> PARADO. Digits and prescaler are held, so the partial tick is preserved.
  - PARADO + start_stop -> CONTANDO. Resumes from the held prescaler value.
  - Any state + clear -> ZERADO. Digits and prescaler go to 0.
  - Clear and start_stop edges in the same cycle: clear wins and start_stop is discarded.
- Prescaler:
  - Increments every cycle in CONTANDO.
  - At DIV-1 it returns to 0 and issues a tick. The first tick comes DIV cycles after entering CONTANDO from ZERADO.
- Tick arithmetic, BCD ripple in one cycle:
  - Hundredths 00..99, seconds 00..59, minutes 00..59, hours 00..99.
  - Each field carries into the next field when it wraps.
- Wrap-around at 99:59:59.99:
  - The tick sets all digits to 0 and pulses estouro for that single cycle.
  - State stays CONTANDO and counting continues.
- Segment encoding:
  - Codes, as bit6..bit0 = g..a: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - chx is registered and follows a digit update by exactly 1 clock.
  - BCD values above 9 cannot occur; the decoder default is 7F (blank).
- running is registered; it goes high the cycle after the start command edge is registered.
- Reset mid-count returns to the full reset values on the next edge regardless of state or pending edges.

Test Plan:
- Reset check (DIV=4): assert reset 2 cycles with start_stop held high -> chx = all 7'h40, running=0; the held start_stop produces no start after release.
- Basic count (DIV=4): one start_stop pulse, run 40 cycles -> hundredths = 10; display 0 = 7'h40, display 1 = 7'h79; running=1.
- Pause/resume (DIV=4): start, stop mid-tick after 10 cycles, wait 20 cycles, resume -> no advance while PARADO; the next tick arrives after the remaining prescaler count, not a full DIV.
- Clear priority: in CONTANDO, pulse clear and start_stop in the same cycle -> state ZERADO, all digits 0, running=0.
- Carry chain: from 00:00:59.99 (reach it by counting with DIV=2), one tick -> 00:01:00.00; display 4 = 7'h79, all other displays = 7'h40.
- Overflow: count to 99:59:59.99 (DIV=2, long run or forced start value), one tick -> all digits 0 and estouro high for exactly 1 cycle; counting continues.
